// File: rtl/seq_divider.sv
// Sequential radix-2 restoring divider for signed two's-complement operands.
// One quotient bit per clock; results and flags are held until the next operation.
module seq_divider #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic             ovf
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;          // partial remainder magnitude
   logic [WIDTH-1:0] dvd_q, dvd_d;          // dividend magnitude, becomes quotient magnitude
   logic [WIDTH-1:0] dsr_q, dsr_d;          // divisor magnitude
   logic [WIDTH-1:0] raw_dvd_q, raw_dvd_d;
   logic             sign_quo_q, sign_quo_d;
   logic             sign_rem_q, sign_rem_d;
   logic             zero_q, zero_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             div_zero_q, div_zero_d;
   logic             ovf_q, ovf_d;
   logic [WIDTH:0]   shifted, trial;

   function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
      return ~v + WIDTH'(1);
   endfunction

   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? negate(v) : v;
   endfunction

   always_comb begin
      // NOTE: every signal gets a hold value first so no path through the case infers a latch.
      state_d     = state_q;
      cnt_d       = cnt_q;
      rem_d       = rem_q;
      dvd_d       = dvd_q;
      dsr_d       = dsr_q;
      raw_dvd_d   = raw_dvd_q;
      sign_quo_d  = sign_quo_q;
      sign_rem_d  = sign_rem_q;
      zero_d      = zero_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      div_zero_d  = div_zero_q;
      ovf_d       = ovf_q;
      shifted     = {rem_q, dvd_q[WIDTH-1]};
      trial       = shifted - {1'b0, dsr_q};

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = CALC;
               dvd_d      = magnitude(dividend);
               dsr_d      = magnitude(divisor);
               raw_dvd_d  = dividend;
               sign_quo_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
               sign_rem_d = dividend[WIDTH-1];
               zero_d     = (divisor == '0);
               cnt_d      = CW'(WIDTH);
               rem_d      = '0;
            end
         end
         CALC: begin
            cnt_d = cnt_q - CW'(1);
            if (!trial[WIDTH]) begin
               rem_d = trial[WIDTH-1:0];
               dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
            end else begin
               rem_d = shifted[WIDTH-1:0];
               dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
            end
            if (cnt_q == CW'(1)) state_d = FIX;
         end
         FIX: begin
            state_d = DONE;
            if (zero_q) begin
               quotient_d  = '1;
               remainder_d = raw_dvd_q;
               div_zero_d  = 1'b1;
               ovf_d       = 1'b0;
            end else begin
               quotient_d  = sign_quo_q ? negate(dvd_q) : dvd_q;
               remainder_d = sign_rem_q ? negate(rem_q) : rem_q;
               div_zero_d  = 1'b0;
               // A positive magnitude of 2^(WIDTH-1) only arises from most-negative / -1.
               ovf_d       = !sign_quo_q && (dvd_q == MOST_NEG);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == CALC) || (state_d == FIX);
      done_d = (state_q == DONE);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         rem_q       <= '0;
         dvd_q       <= '0;
         dsr_q       <= '0;
         raw_dvd_q   <= '0;
         sign_quo_q  <= 1'b0;
         sign_rem_q  <= 1'b0;
         zero_q      <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         div_zero_q  <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rem_q       <= rem_d;
         dvd_q       <= dvd_d;
         dsr_q       <= dsr_d;
         raw_dvd_q   <= raw_dvd_d;
         sign_quo_q  <= sign_quo_d;
         sign_rem_q  <= sign_rem_d;
         zero_q      <= zero_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         div_zero_q  <= div_zero_d;
         ovf_q       <= ovf_d;
      end
   end

   assign quotient  = quotient_q;
   assign remainder = remainder_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign div_zero  = div_zero_q;
   assign ovf       = ovf_q;

endmodule
